// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, the master state encoding,
// and the helper that classifies a response as an error.
package axi_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_WR,
    ST_B,
    ST_RSP
  } mst_state_t;

  // Anything other than OKAY is reported to the core as an error; EXOKAY
  // counts as an error because exclusive accesses are never issued here.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != OKAY);
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bus bundle (AW/W/B/AR/R) with initiator and target views.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_perf_cnt.sv
// Free-running activity counters for the AXI-Lite master: completed reads,
// completed writes, and cycles spent waiting on the bus. All wrap at 2^32.
module axi_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_hs,
  input  logic        wr_hs,
  input  logic        wait_cyc,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic [31:0] wait_cnt
);

  // Count events; natural 32-bit overflow gives the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      wait_cnt <= '0;
    end else begin
      if (rd_hs)    rd_cnt   <= rd_cnt + 32'd1;
      if (wr_hs)    wr_cnt   <= wr_cnt + 32'd1;
      if (wait_cyc) wait_cnt <= wait_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator bridging a simple core request /
// response port onto the AW/W/B/AR/R channels.
// Optional build macro AXI_LITE_MASTER_PERF_EN adds perf_rd_cnt, perf_wr_cnt
// and perf_wait_cnt outputs backed by axi_perf_cnt.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  axi_lite_if.master          axi
`ifdef AXI_LITE_MASTER_PERF_EN
  ,
  output logic [31:0]         perf_rd_cnt,
  output logic [31:0]         perf_wr_cnt,
  output logic [31:0]         perf_wait_cnt
`endif
);

  mst_state_t          state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                we_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic                arvalid_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                rready_q;
  logic                bready_q;
  logic                rsp_valid_q;
  logic                aw_hs;
  logic                w_hs;

  assign aw_hs = awvalid_q & axi.awready;
  assign w_hs  = wvalid_q  & axi.wready;

  // Transaction sequencer; every bus-facing strobe is a flop set on the
  // transition into the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= OKAY;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            we_q    <= req_we;
            if (req_we) begin
              state     <= ST_WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
            end else begin
              state     <= ST_AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        ST_AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_R;
          end
        end
        ST_R: begin
          if (axi.rvalid) begin
            rready_q    <= 1'b0;
            rdata_q     <= axi.rdata;
            resp_q      <= axi.rresp;
            rsp_valid_q <= 1'b1;
            state       <= ST_RSP;
          end
        end
        ST_WR: begin
          // AW and W retire independently; leave once both have, even if
          // they complete on the same edge.
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state     <= ST_B;
          end else begin
            aw_done_q <= aw_done_q | aw_hs;
            w_done_q  <= w_done_q | w_hs;
          end
        end
        ST_B: begin
          if (axi.bvalid) begin
            bready_q    <= 1'b0;
            resp_q      <= axi.bresp;
            rsp_valid_q <= 1'b1;
            state       <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  // Writes return no data, so mask whatever an earlier read left behind.
  assign rsp_rdata   = we_q ? '0 : rdata_q;
  assign rsp_err     = resp_is_err(resp_q);

  assign axi.araddr  = addr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awaddr  = addr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

`ifdef AXI_LITE_MASTER_PERF_EN
  logic perf_rd_hs;
  logic perf_wr_hs;
  logic perf_wait;

  assign perf_rd_hs = (state == ST_R) & axi.rvalid;
  assign perf_wr_hs = (state == ST_B) & axi.bvalid;
  assign perf_wait  = (state == ST_AR) | (state == ST_R) |
                      (state == ST_WR) | (state == ST_B);

  axi_perf_cnt u_perf (
    .clk      (clk),
    .rst      (rst),
    .rd_hs    (perf_rd_hs),
    .wr_hs    (perf_wr_hs),
    .wait_cyc (perf_wait),
    .rd_cnt   (perf_rd_cnt),
    .wr_cnt   (perf_wr_cnt),
    .wait_cnt (perf_wait_cnt)
  );
`endif

endmodule
